// File: rtl/risc_core_mc.sv
// Multi-cycle RISC core: FETCH/DECODE/EXEC control FSM, 4-entry register file,
// ALU with N/Z flags, internal data memory and a valid/ready output port.
module risc_core_mc #(
   parameter int DATA_W  = 8,
   parameter int IMEM_AW = 8,
   parameter int DMEM_AW = 4
) (
   input  logic               clk,
   input  logic               rst,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [15:0]        imem_rdata,
   input  logic [DATA_W-1:0]  in_data,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               flag_n,
   output logic               flag_z,
   output logic [3:0]         opcode,
   output logic               halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_OUTW,
      S_HALT
   } state_t;

   state_t             r_state;
   logic [IMEM_AW-1:0] r_pc;
   logic [15:0]        r_ir;
   logic [DATA_W-1:0]  r_rf [4];
   logic [DATA_W-1:0]  r_dmem [2**DMEM_AW];
   logic               r_flag_n;
   logic               r_flag_z;
   logic [DATA_W-1:0]  r_out_data;
   logic               r_out_valid;
   logic               r_halted;

   logic [3:0]         w_op;
   logic [1:0]         w_rd;
   logic [1:0]         w_rs;
   logic [7:0]         w_imm;
   logic [DATA_W-1:0]  w_imm_d;
   logic [IMEM_AW-1:0] w_target;
   logic [DMEM_AW-1:0] w_daddr;
   logic [DATA_W-1:0]  w_rd_val;
   logic [DATA_W-1:0]  w_rs_val;
   logic [DATA_W-1:0]  w_alu;

   assign w_op     = r_ir[15:12];
   assign w_rd     = r_ir[11:10];
   assign w_rs     = r_ir[9:8];
   assign w_imm    = r_ir[7:0];
   assign w_daddr  = w_imm[DMEM_AW-1:0];
   assign w_rd_val = r_rf[w_rd];
   assign w_rs_val = r_rf[w_rs];

   // The immediate is zero-extended or truncated to whichever width consumes it.
   generate
      if (DATA_W > 8) begin : g_imm_ext
         assign w_imm_d = {{(DATA_W-8){1'b0}}, w_imm};
      end else begin : g_imm_eq
         assign w_imm_d = w_imm;
      end
      if (IMEM_AW > 8) begin : g_tgt_ext
         assign w_target = {{(IMEM_AW-8){1'b0}}, w_imm};
      end else begin : g_tgt_trunc
         assign w_target = w_imm[IMEM_AW-1:0];
      end
   endgenerate

   always_comb begin
      w_alu = '0;
      case (w_op)
         4'h2:    w_alu = w_rd_val + w_rs_val;
         4'h3:    w_alu = w_rd_val - w_rs_val;
         4'h4:    w_alu = w_rd_val & w_rs_val;
         4'h5:    w_alu = w_rd_val | w_rs_val;
         4'h6:    w_alu = w_rd_val ^ w_rs_val;
         4'h7:    w_alu = ~w_rs_val;
         default: w_alu = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_FETCH;
         r_pc        <= '0;
         r_ir        <= '0;
         for (int i = 0; i < 4; i++) r_rf[i] <= '0;
         r_flag_n    <= 1'b0;
         r_flag_z    <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               r_ir    <= imem_rdata;
               r_pc    <= r_pc + 1'b1;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_state <= S_FETCH;
               case (w_op)
                  4'h1: r_rf[w_rd] <= w_imm_d;
                  4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                     r_rf[w_rd] <= w_alu;
                     r_flag_z   <= (w_alu == '0);
                     r_flag_n   <= w_alu[DATA_W-1];
                  end
                  4'h8: r_rf[w_rd] <= r_dmem[w_daddr];
                  4'hA: r_rf[w_rd] <= in_data;
                  4'hB: begin
                     r_out_data  <= w_rs_val;
                     r_out_valid <= 1'b1;
                     r_state     <= S_OUTW;
                  end
                  4'hC: r_pc <= w_target;
                  4'hD: if (r_flag_z) r_pc <= w_target;
                  4'hE: if (r_flag_n) r_pc <= w_target;
                  4'hF: begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end
                  default: begin end
               endcase
            end
            S_OUTW: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_FETCH;
               end
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // Data memory keeps its contents across reset; only the store in EXEC writes it.
   always_ff @(posedge clk) begin
      if (!rst && r_state == S_EXEC && w_op == 4'h9)
         r_dmem[w_daddr] <= w_rs_val;
   end

   assign imem_addr = r_pc;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign flag_n    = r_flag_n;
   assign flag_z    = r_flag_z;
   assign opcode    = r_ir[15:12];
   assign halted    = r_halted;

endmodule

// File: tb/tb_risc_core_mc.sv
// Bench for risc_core_mc: instruction-level reference model checked every cycle,
// directed programs with literal expectations, and randomized programs.
module tb_risc_core_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  imem_addr;
   logic [15:0] rom_q;
   logic [7:0]  in_data = '0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        flag_n, flag_z;
   logic [3:0]  opcode;
   logic        halted;

   logic        rst4 = 1'b1;
   logic [3:0]  imem_addr4;
   logic [15:0] rom4_q = 16'h0000;
   logic [7:0]  in_data4 = '0;
   logic [7:0]  out_data4;
   logic        out_valid4;
   logic        out_ready4 = 1'b1;
   logic        flag_n4, flag_z4;
   logic [3:0]  opcode4;
   logic        halted4;

   logic [15:0] rom [256];

   always #5 clk = ~clk;
   always @(posedge clk) rom_q <= rom[imem_addr];

   risc_core_mc #(.DATA_W(8), .IMEM_AW(8), .DMEM_AW(4)) u_dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(rom_q),
      .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .flag_n(flag_n), .flag_z(flag_z),
      .opcode(opcode), .halted(halted)
   );

   // Narrow-PC instance fed by a ROM of NOPs.
   risc_core_mc #(.DATA_W(8), .IMEM_AW(4), .DMEM_AW(4)) u_dut4 (
      .clk(clk), .rst(rst4), .imem_addr(imem_addr4), .imem_rdata(rom4_q),
      .in_data(in_data4), .out_data(out_data4), .out_valid(out_valid4),
      .out_ready(out_ready4), .flag_n(flag_n4), .flag_z(flag_z4),
      .opcode(opcode4), .halted(halted4)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] m_pc;
   logic [3:0] m_op;
   logic [7:0] m_rf [4];
   logic [7:0] m_dm [16];
   logic [7:0] m_od;
   logic       m_n, m_z, m_halt;

   function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
      logic [3:0] o;
      logic [1:0] d;
      logic [1:0] s;
      logic [7:0] i;
      o = 4'(op); d = 2'(rd); s = 2'(rs); i = 8'(imm);
      return {o, d, s, i};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic m_reset();
      m_pc = '0; m_op = '0; m_od = '0;
      m_n = 1'b0; m_z = 1'b0; m_halt = 1'b0;
      for (int i = 0; i < 4; i++) m_rf[i] = '0;
   endtask

   task automatic chk_cycle(input logic ov);
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("opcode",    32'(opcode),    32'(m_op));
      chk("flag_n",    32'(flag_n),    32'(m_n));
      chk("flag_z",    32'(flag_z),    32'(m_z));
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("out_data",  32'(out_data),  32'(m_od));
      chk("halted",    32'(halted),    32'(m_halt));
   endtask

   // Architectural effect of one instruction.
   task automatic m_exec(input logic [15:0] ins, input logic [7:0] inv, output bit is_out);
      logic [3:0] op;
      logic [1:0] rd, rs;
      logic [7:0] imm, a, b, res;
      bit alu;
      op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
      a = m_rf[rd]; b = m_rf[rs]; res = '0; alu = 1'b0; is_out = 1'b0;
      case (op)
         4'd1:  m_rf[rd] = imm;
         4'd2:  begin res = a + b; alu = 1'b1; end
         4'd3:  begin res = a - b; alu = 1'b1; end
         4'd4:  begin res = a & b; alu = 1'b1; end
         4'd5:  begin res = a | b; alu = 1'b1; end
         4'd6:  begin res = a ^ b; alu = 1'b1; end
         4'd7:  begin res = ~b;    alu = 1'b1; end
         4'd8:  m_rf[rd] = m_dm[imm[3:0]];
         4'd9:  m_dm[imm[3:0]] = b;
         4'd10: m_rf[rd] = inv;
         4'd11: begin m_od = b; is_out = 1'b1; end
         4'd12: m_pc = imm;
         4'd13: if (m_z) m_pc = imm;
         4'd14: if (m_n) m_pc = imm;
         4'd15: m_halt = 1'b1;
         default: begin end
      endcase
      if (alu) begin
         m_rf[rd] = res;
         m_z = (res == 8'h00);
         m_n = res[7];
      end
   endtask

   // rmode >= 0: ready low for rmode wait cycles; -1: random ready; -2: reset in wait.
   task automatic step(input int rmode, output int vcnt);
      logic [15:0] ins;
      logic [7:0]  inv;
      bit          is_out, r;
      vcnt = 0;
      ins = rom[m_pc];
      chk_cycle(1'b0);
      out_ready = 1'($urandom);
      tick();
      chk_cycle(1'b0);
      tick();
      m_pc = m_pc + 8'd1;
      m_op = ins[15:12];
      chk_cycle(1'b0);
      inv = 8'($urandom);
      in_data = inv;
      m_exec(ins, inv, is_out);
      tick();
      if (is_out) begin
         for (int k = 0; k < 64; k++) begin
            chk_cycle(1'b1);
            if (out_valid) vcnt++;
            if (rmode == -2 && k == 2) begin
               rst = 1'b1;
               out_ready = 1'b0;
               tick();
               chk("abort_out_valid", 32'(out_valid), 32'd0);
               chk("abort_pc", 32'(imem_addr), 32'd0);
               m_reset();
               rst = 1'b0;
               return;
            end
            if (rmode >= 0)       r = (k >= rmode);
            else if (rmode == -1) r = ($urandom_range(0, 2) == 0) || (k >= 8);
            else                  r = 1'b0;
            out_ready = r;
            tick();
            if (r) break;
         end
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      m_reset();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v, c0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[0]  = enc(1, 0, 0, 8'h80);
      rom[1]  = enc(1, 1, 0, 8'h80);
      rom[2]  = enc(2, 0, 1, 0);
      rom[3]  = enc(3, 0, 1, 0);
      rom[4]  = enc(11, 0, 0, 0);
      rom[5]  = enc(1, 2, 0, 8'h5A);
      rom[6]  = enc(9, 0, 2, 3);
      rom[7]  = enc(1, 2, 0, 0);
      rom[8]  = enc(8, 3, 0, 3);
      rom[9]  = enc(11, 0, 3, 0);
      rom[10] = enc(1, 0, 0, 3);
      rom[11] = enc(1, 1, 0, 1);
      rom[12] = enc(3, 0, 1, 0);
      rom[13] = enc(13, 0, 0, 15);
      rom[14] = enc(12, 0, 0, 12);
      rom[15] = enc(15, 0, 0, 0);

      // Reset held for two edges.
      tick();
      tick();
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_halted",    32'(halted),    32'd0);
      chk("rst_opcode",    32'(opcode),    32'd0);
      rst = 1'b0;
      m_reset();

      step(-1, v);
      chk("first_pc_advance", 32'(imem_addr), 32'd1);
      step(-1, v);
      step(-1, v);
      chk("add_wrap_z", 32'(flag_z), 32'd1);
      chk("add_wrap_n", 32'(flag_n), 32'd0);
      step(-1, v);
      chk("sub_z", 32'(flag_z), 32'd0);
      chk("sub_n", 32'(flag_n), 32'd1);
      step(-1, v);
      chk("out_r0", 32'(out_data), 32'h80);
      for (int i = 0; i < 4; i++) step(-1, v);
      step(5, v);
      chk("hs_valid_cycles", 32'(v), 32'd6);
      chk("mem_out", 32'(out_data), 32'h5A);

      c0 = cyc;
      for (int s = 0; s < 20 && !m_halt; s++) step(-1, v);
      chk("loop_cycles", 32'(cyc - c0), 32'(6 + 3 * 9 - 3 + 3));
      chk("loop_halted", 32'(halted), 32'd1);
      chk("loop_z", 32'(flag_z), 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk_cycle(1'b0);
         tick();
      end

      // Randomized programs; the prefix initialises all of data memory.
      for (int i = 0; i < 16; i++) begin
         rom[2*i]   = enc(1, 0, 0, $urandom_range(0, 255));
         rom[2*i+1] = enc(9, 0, 0, i);
      end
      for (int i = 32; i < 256; i++)
         rom[i] = enc($urandom_range(0, 14), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 255));
      apply_reset();
      for (int i = 0; i < 400; i++) step(-1, v);

      // Reset while an output transfer is pending.
      rom[0] = enc(1, 1, 0, 8'h33);
      rom[1] = enc(11, 0, 1, 0);
      apply_reset();
      step(-1, v);
      step(-2, v);
      step(-1, v);
      chk("restart_pc", 32'(imem_addr), 32'd1);

      // 4-bit PC wraps from 15 to 0.
      rst4 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("pc4_fetch", 32'(imem_addr4), 32'(i % 16));
         tick();
         tick();
         tick();
      end
      tick();
      rst4 = 1'b1;
      tick();
      chk("pc4_reset", 32'(imem_addr4), 32'd0);
      chk("pc4_halted", 32'(halted4), 32'd0);
      chk("pc4_valid", 32'(out_valid4), 32'd0);
      rst4 = 1'b0;
      tick();
      tick();
      chk("pc4_restart", 32'(imem_addr4), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
